dmem_arbiter: RTL and testbench

//  Shares the single 512x32 data memory between two requesters (port 0 = CPU load/store, port 1 = debug/DMA).

---
 rtl/dmem_arbiter_pkg.sv | 25 ++
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter_rr.sv | 34 +++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dmem_arb_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;

  // Requester identities; also the index into the one-hot grant vector.
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Collapse a one-hot 2-bit grant into the winning port number.
  function automatic logic grant_port(input logic [1:0] grant);
    return grant[1] ? PORT_DBG : PORT_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side bundle of the data-memory arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req with stable fields until their gnt pulse.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);

  // Port 0: CPU load/store
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic              p0_fault;

  // Port 1: debug / DMA
  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;
  logic              p1_fault;

  // Memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view: serves requests and owns the memory strobes.
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_fault,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata, p1_fault,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Environment view: requesters plus the memory itself.
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_fault,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_fault,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin picker: one-hot grant, alternates when both ports request.
// Latency: grant is combinational from req; pointer moves on the advance cycle.
// Backpressure: none; a non-advanced grant leaves the pointer untouched.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Port favoured on a tie; flips to the other port after each grant.
  logic ptr;

  // Single requester always wins; on a tie the pointer decides.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (ptr == PORT_DBG) ? 2'b10 : 2'b01;
    end
  end

  // Favour whichever port was not just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PORT_CPU;
    end else if (advance && (grant != 2'b00)) begin
      ptr <= (grant_port(grant) == PORT_CPU) ? PORT_DBG : PORT_CPU;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data memory between CPU (port 0) and debug/DMA (port 1) with SETUP/STROBE/DONE sequencing.
// Latency: gnt in cycle T, rvalid in T+3; one access per 4 cycles.
// Backpressure: requests seen only in IDLE; the losing/other port stays pending until a later IDLE.
// Optional: DMEM_RO_FAULT_EN rejects writes into [RO_BASE, RO_LIMIT] with fault=1 and no strobe.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RO_BASE  = ADDR_W'(256),
  parameter logic [ADDR_W-1:0] RO_LIMIT = ADDR_W'(383)
) (
  input logic          clk,
  input logic          rst_n,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_RO_FAULT_EN
  localparam bit RO_CHECK = 1'b1;
`else
  localparam bit RO_CHECK = 1'b0;
`endif

  state_t            state;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              advance;
  logic              lat_port;
  logic              lat_we;
  logic              lat_fault;
  logic              ro_hit;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [1:0]        rvalid_q;
  logic [1:0]        fault_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  assign req     = {bus.p1_req, bus.p0_req};
  assign advance = (state == ST_IDLE) && (req != 2'b00);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  // A write landing in the read-only window; constant 0 when the check is compiled out.
  assign ro_hit = RO_CHECK && lat_we &&
                  (mem_addr_q >= RO_BASE) && (mem_addr_q <= RO_LIMIT);

  // Access sequencer: latch on grant, settle address, strobe once, report.
  // A faulted write still spends the strobe slot (strobes held low) so rvalid is always at T+3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lat_port    <= PORT_CPU;
      lat_we      <= 1'b0;
      lat_fault   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      rvalid_q    <= 2'b00;
      fault_q     <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (advance) begin
            lat_port <= grant_port(grant);
            if (grant_port(grant) == PORT_DBG) begin
              lat_we      <= bus.p1_we;
              mem_addr_q  <= bus.p1_addr;
              mem_wdata_q <= bus.p1_wdata;
            end else begin
              lat_we      <= bus.p0_we;
              mem_addr_q  <= bus.p0_addr;
              mem_wdata_q <= bus.p0_wdata;
            end
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          lat_fault   <= ro_hit;
          mem_read_q  <= !lat_we;
          mem_write_q <= lat_we && !ro_hit;
          state       <= ST_STROBE;
        end
        ST_STROBE: begin
          mem_read_q         <= 1'b0;
          mem_write_q        <= 1'b0;
          rvalid_q[lat_port] <= 1'b1;
          fault_q[lat_port]  <= lat_fault;
          if (lat_port == PORT_DBG) begin
            rdata1_q <= lat_we ? '0 : bus.mem_rdata;
          end else begin
            rdata0_q <= lat_we ? '0 : bus.mem_rdata;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          rvalid_q    <= 2'b00;
          fault_q     <= 2'b00;
          rdata0_q    <= '0;
          rdata1_q    <= '0;
          lat_fault   <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Grant must land in the same IDLE cycle the request is seen, hence combinational.
  assign bus.p0_gnt    = advance && grant[PORT_CPU];
  assign bus.p1_gnt    = advance && grant[PORT_DBG];

  assign bus.p0_rvalid = rvalid_q[PORT_CPU];
  assign bus.p1_rvalid = rvalid_q[PORT_DBG];
  assign bus.p0_fault  = fault_q[PORT_CPU];
  assign bus.p1_fault  = fault_q[PORT_DBG];
  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single accesses, tie arbitration, reset during a write strobe.
// Latency: expects gnt at T, strobe at T+2, rvalid at T+3.
// Backpressure: requesters hold req until gnt, then drop it (held in the arbitration sequence).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int AW = 9;
  localparam int DW = 32;
`ifdef DMEM_RO_FAULT_EN
  localparam logic RO = 1'b1;
`else
  localparam logic RO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: combinational read, write on the rising edge of mem_write.
  logic [DW-1:0] mem [0:511];
  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge bus.mem_write) mem[bus.mem_addr] = bus.mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard of completions expected from the DUT.
  typedef struct {
    logic        port;
    int          cyc;
    logic [31:0] rdata;
    logic        fault;
  } sb_t;
  sb_t sb[$];
  sb_t e;

  logic prev_g0 = 1'b0;
  logic prev_g1 = 1'b0;

  // Per-cycle protocol checks and completion matching.
  always @(negedge clk) begin
    check("strobe_exclusive", {63'd0, bus.mem_read & bus.mem_write}, 64'd0);
    check("gnt_one_cycle", {62'd0, prev_g1 & bus.p1_gnt, prev_g0 & bus.p0_gnt}, 64'd0);
    prev_g0 = bus.p0_gnt;
    prev_g1 = bus.p1_gnt;
    if (bus.p0_rvalid || bus.p1_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", {62'd0, bus.p1_rvalid, bus.p0_rvalid}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rvalid_port", {62'd0, bus.p1_rvalid, bus.p0_rvalid}, e.port ? 64'd2 : 64'd1);
        check("rvalid_cycle", 64'(cyc), 64'(e.cyc));
        check("rdata", e.port ? 64'(bus.p1_rdata) : 64'(bus.p0_rdata), 64'(e.rdata));
        check("fault", e.port ? 64'(bus.p1_fault) : 64'(bus.p0_fault), 64'(e.fault));
      end
    end
  end

  task automatic set_port(input logic p, input logic req, input logic we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (p) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = addr; bus.p1_wdata = wdata;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = addr; bus.p0_wdata = wdata;
    end
  endtask

  // Wait (bounded) for the given port's gnt; returns the grant cycle or -1.
  task automatic wait_gnt(input logic p, output int t);
    t = -1;
    for (int i = 0; i < 20 && t < 0; i++) begin
      @(negedge clk);
      if (p ? bus.p1_gnt : bus.p0_gnt) t = cyc;
    end
    check("gnt_seen", {63'd0, t >= 0}, 64'd1);
  endtask

  // One complete access with cycle-by-cycle checks of the memory side.
  task automatic access(input logic p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input logic exp_fault);
    int t;
    @(posedge clk); #1;
    set_port(p, 1'b1, we, addr, wdata);
    wait_gnt(p, t);
    if (t >= 0) sb.push_back('{p, t + 3, exp_rdata, exp_fault});
    @(posedge clk); #1;
    set_port(p, 1'b0, 1'b0, '0, '0);
    if (t < 0) return;
    @(negedge clk);  // SETUP
    check("setup_addr", 64'(bus.mem_addr), 64'(addr));
    check("setup_strobes", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
    @(negedge clk);  // STROBE
    check("strobe_addr", 64'(bus.mem_addr), 64'(addr));
    check("strobe_kind", {62'd0, bus.mem_read, bus.mem_write},
          {62'd0, !we, we && !exp_fault});
    if (we) check("strobe_wdata", 64'(bus.mem_wdata), 64'(wdata));
    @(negedge clk);  // DONE
    check("done_strobes", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
    check("done_addr", 64'(bus.mem_addr), 64'(addr));
    @(negedge clk);  // IDLE
    check("idle_addr", 64'(bus.mem_addr), 64'd0);
    check("idle_wdata", 64'(bus.mem_wdata), 64'd0);
  endtask

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_fault;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int order[4];
    int last_t;
    int n_g;
    int t;
    bit seen;

    for (int i = 0; i < 512; i++) mem[i] = 32'(i + 1);
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);

    tbl[0]  = '{1'b0, 1'b0, 9'd0,   32'h0,        32'h00000001, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 9'd5,   32'hA5A5A5A5, 32'h0,        1'b0};
    tbl[2]  = '{1'b0, 1'b0, 9'd5,   32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 9'd5,   32'h0,        32'hA5A5A5A5, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 9'd511, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[5]  = '{1'b1, 1'b0, 9'd511, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 9'd256, 32'h0,        32'd257,      1'b0};
    tbl[7]  = '{1'b0, 1'b1, 9'd256, 32'h12345678, 32'h0,        RO};
    tbl[8]  = '{1'b1, 1'b0, 9'd256, 32'h0,        RO ? 32'd257 : 32'h12345678, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 9'd383, 32'h0F0F0F0F, 32'h0,        RO};
    tbl[10] = '{1'b0, 1'b0, 9'd383, 32'h0,        RO ? 32'd384 : 32'h0F0F0F0F, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 9'd384, 32'h55AA55AA, 32'h0,        1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_gnt",    {62'd0, bus.p1_gnt, bus.p0_gnt}, 64'd0);
    check("rst_rvalid", {62'd0, bus.p1_rvalid, bus.p0_rvalid}, 64'd0);
    check("rst_fault",  {62'd0, bus.p1_fault, bus.p0_fault}, 64'd0);
    check("rst_strobe", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
    check("rst_addr",   64'(bus.mem_addr), 64'd0);
    check("rst_rdata",  {bus.p1_rdata, bus.p0_rdata}, 64'd0);
    rst_n = 1'b1;

    // Table of single accesses
    for (int i = 0; i < 12; i++) begin
      access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_rdata, tbl[i].exp_fault);
    end
    access(1'b0, 1'b0, 9'd384, 32'h0, 32'h55AA55AA, 1'b0);

    // Tie arbitration right after reset: both held, must alternate starting with port 0.
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    set_port(1'b0, 1'b1, 1'b0, 9'd0, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 9'd5, 32'h0);
    n_g = 0;
    last_t = 0;
    for (int i = 0; i < 40 && n_g < 4; i++) begin
      @(negedge clk);
      if (bus.p0_gnt || bus.p1_gnt) begin
        check("tie_single_gnt", {62'd0, bus.p1_gnt, bus.p0_gnt}, bus.p1_gnt ? 64'd2 : 64'd1);
        if (n_g > 0) check("tie_spacing", 64'(cyc - last_t), 64'd4);
        order[n_g] = bus.p1_gnt ? 1 : 0;
        sb.push_back('{bus.p1_gnt, cyc + 3, bus.p1_gnt ? 32'hA5A5A5A5 : 32'h00000001, 1'b0});
        last_t = cyc;
        n_g++;
        if (n_g == 4) begin
          @(posedge clk); #1;
          set_port(1'b0, 1'b0, 1'b0, '0, '0);
          set_port(1'b1, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    check("tie_gnt_count", 64'(n_g), 64'd4);
    for (int k = 0; k < n_g; k++) check("tie_order", 64'(order[k]), 64'(k % 2));
    repeat (6) @(negedge clk);
    check("tie_drained", 64'(sb.size()), 64'd0);

    // Reset during the strobe of a write: no completion, write committed.
    @(posedge clk); #1;
    set_port(1'b1, 1'b1, 1'b1, 9'd10, 32'hC0FFEE00);
    wait_gnt(1'b1, t);
    @(posedge clk); #1;
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    seen = 0;
    for (int i = 0; i < 5 && !seen; i++) begin
      @(negedge clk);
      if (bus.mem_write) seen = 1;
    end
    check("rst_mid_strobe_seen", {63'd0, seen}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_strobes", {62'd0, bus.mem_read, bus.mem_write}, 64'd0);
    check("rst_mid_addr", 64'(bus.mem_addr), 64'd0);
    check("rst_mid_rvalid", {62'd0, bus.p1_rvalid, bus.p0_rvalid}, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 9'd10, 32'h0, 32'hC0FFEE00, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
